av2_obu_dispatch: RTL and testbench
===================================

Name: av2_obu_dispatch

Overview:
- Sequences the OBU parser output and routes each OBU's payload to one of three downstream decoders: sequence header, frame/frame header, and tile group.
- Accepts one header (type, size) over a valid/ready handshake.
- Forwards exactly ceil(size/BYTES) payload beats to the selected sink with correct tkeep/tlast, or drops them if the type is unsupported.
- Sits between av2_obu_parser and the header/tile decoders; provides status counters and sticky length-error flags.

Parameters:
- DATA_WIDTH, 128, payload beat width in bits; must be a multiple of 8.
- BYTES, DATA_WIDTH/8 (16), bytes per beat; derived, not overridable.
- CNT_W, 16, width of the drop and OBU counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- obu_type  in  4  header type from parser.
- obu_size  in  32  payload size in bytes.
- obu_valid  in  1  header valid.
- obu_ready  out  1  header accepted when valid&ready.
- pl_tdata  in  DATA_WIDTH  payload stream.
- pl_tvalid  in  1  payload valid.
- pl_tready  out  1  payload ready.
- pl_tlast  in  1  upstream end-of-OBU marker.
- m_tdata  out  DATA_WIDTH  shared sink data (pass-through of pl_tdata).
- m_tkeep  out  BYTES  byte enables.
- m_tlast  out  1  last beat of OBU.
- m_tvalid  out  3  per-sink valid; [0]=seq hdr, [1]=frame, [2]=tile group.
- m_tready  in  3  per-sink ready.
- td_pulse  out  1  one-cycle pulse on temporal-delimiter header accept.
- obu_cnt  out  CNT_W  headers accepted, wrapping.
- drop_cnt  out  CNT_W  OBUs dropped, wrapping.
- err_short  out  1  sticky: pl_tlast before counted end.
- err_long  out  1  sticky: counted end without pl_tlast.
- err_clr  in  1  clears both sticky errors.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0. obu_ready is also 0 during reset, then 1 in IDLE.
- FSM states: IDLE, FWD, DROP.
- IDLE:
  - obu_ready=1 and pl_tready=0.
  - On obu_valid, latch the type; load rem = obu_size (32b byte count remaining); increment obu_cnt.
  - Type 1 selects sink 0. Types 3 and 6 select sink 1. Type 4 selects sink 2.
  - Type 2 (temporal delimiter): pulse td_pulse the next cycle; no payload is expected.
  - Any other type: increment drop_cnt.
  - If obu_size==0, stay in IDLE (no payload beats, no sink activity).
  - Otherwise go to FWD for a supported type, or DROP for an unsupported type (including type 2 with nonzero size).
- Latency: a header accepted at cycle N allows the first payload transfer at cycle N+1. Payload is combinational pass-through with no added latency.
- FWD:
  - m_tvalid[sel] = pl_tvalid; the other bits are 0.
  - pl_tready = m_tready[sel]. m_tdata = pl_tdata.
  - Beat transfers when pl_tvalid & pl_tready.
  - Last beat is when rem <= BYTES:
    - m_tlast=1.
    - m_tkeep[i] = (i < rem) for rem < BYTES, otherwise all ones.
    - Non-last beats use all-ones tkeep.
  - On each transfer, rem <= rem - BYTES. On the last transfer, return to IDLE.
- DROP: pl_tready=1, m_tvalid=0. Same rem counting and exit rule as FWD.
- Length checks, evaluated per transferred beat:
  - pl_tlast on a non-last beat: set err_short, terminate the OBU immediately, assert m_tlast on that beat (FWD), return to IDLE.
  - Last beat without pl_tlast: set err_long and return to IDLE. Subsequent upstream beats are then presented to the next header decode.
- Error flag priority: err_clr clears the flags, but a set event in the same cycle wins.
- obu_ready stays 0 outside IDLE, so the parser holds its header; no header is ever lost or double-accepted.
- Counters wrap modulo 2^CNT_W.
- Asynchronous reset mid-OBU returns to IDLE immediately and clears counters, flags and rem; no partial tlast is emitted.

Decomposition:
- Package av2_obu_pkg holds:
  - OBU type constants (SEQ_HDR=1, TD=2, FRAME_HDR=3, TILE_GROUP=4, FRAME=6).
  - Sink index constants.
  - FSM state encoding.
- Sub-module av2_obu_keep_gen: combinational rem[4:0] -> tkeep[BYTES-1:0], reusable by other stream blocks.

Test Plan:
- Type 1, size 40, three beats with tlast on beat 3 -> sink 0 gets 3 beats; beat 3 has m_tkeep=16'h00FF and m_tlast=1; obu_cnt=1; busy returns 0 the cycle after.
- Type 4, size 32, m_tready[2] toggled 1,0,0,1,1 -> exactly 2 transfers with data unchanged; tkeep=16'hFFFF on both; pl_tready mirrors m_tready[2].
- Type 2, size 0, then type 6, size 16 -> td_pulse for one cycle; no payload consumed for the TD; type 6 beat goes to m_tvalid[1] with m_tlast=1.
- Type 9, size 20 -> drop_cnt=1; 2 beats consumed with pl_tready=1 and m_tvalid=3'b000.
- Type 3, size 48, pl_tlast on beat 2 -> err_short=1, m_tlast on beat 2, return to IDLE. Pulse err_clr -> err_short=0. Type 3, size 16 without tlast -> err_long=1.
- rst_n asserted mid-FWD after 1 of 4 beats -> next cycle IDLE, obu_ready=1 after release, counters 0, no m_tvalid.

Source files
------------

// File: rtl/av2_obu_pkg.sv
// Shared OBU type codes, sink indices and dispatch FSM encoding for the
// AV2 OBU dispatch slice.
package av2_obu_pkg;

  localparam logic [3:0] OBU_SEQ_HDR    = 4'd1;
  localparam logic [3:0] OBU_TD         = 4'd2;
  localparam logic [3:0] OBU_FRAME_HDR  = 4'd3;
  localparam logic [3:0] OBU_TILE_GROUP = 4'd4;
  localparam logic [3:0] OBU_FRAME      = 4'd6;

  localparam logic [1:0] SINK_SEQ   = 2'd0;
  localparam logic [1:0] SINK_FRAME = 2'd1;
  localparam logic [1:0] SINK_TILE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_DROP
  } state_e;

  typedef struct packed {
    logic       ok;
    logic [1:0] sink;
  } route_t;

  // ok is set only for types that carry payload to a decoder; TD is handled apart.
  function automatic route_t route_of(input logic [3:0] t);
    route_t r;
    r.ok   = 1'b0;
    r.sink = SINK_SEQ;
    case (t)
      OBU_SEQ_HDR:    begin r.ok = 1'b1; r.sink = SINK_SEQ;   end
      OBU_FRAME_HDR,
      OBU_FRAME:      begin r.ok = 1'b1; r.sink = SINK_FRAME; end
      OBU_TILE_GROUP: begin r.ok = 1'b1; r.sink = SINK_TILE;  end
      default:        begin r.ok = 1'b0; r.sink = SINK_SEQ;   end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/av2_obu_keep_gen.sv
// Byte-enable generator: remaining byte count -> tkeep, all ones when the
// count covers a full beat.
module av2_obu_keep_gen #(
  parameter int BYTES = 16,
  parameter int REM_W = $clog2(BYTES) + 1
) (
  input  logic [REM_W-1:0] rem_i,
  output logic [BYTES-1:0] tkeep_o
);

  always_comb begin
    tkeep_o = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      tkeep_o[i] = (32'(rem_i) >= BYTES) || (i < 32'(rem_i));
    end
  end

endmodule

// File: rtl/av2_obu_dispatch.sv
// Routes each OBU payload from the parser to the sequence-header, frame or
// tile-group decoder, or drops it, with length checking and status counters.
module av2_obu_dispatch
  import av2_obu_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              obu_type,
  input  logic [31:0]             obu_size,
  input  logic                    obu_valid,
  output logic                    obu_ready,
  input  logic [DATA_WIDTH-1:0]   pl_tdata,
  input  logic                    pl_tvalid,
  output logic                    pl_tready,
  input  logic                    pl_tlast,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic [2:0]              m_tvalid,
  input  logic [2:0]              m_tready,
  output logic                    td_pulse,
  output logic [CNT_W-1:0]        obu_cnt,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    err_short,
  output logic                    err_long,
  input  logic                    err_clr,
  output logic                    busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int REM_W = $clog2(BYTES) + 1;

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [31:0]        rem_q, rem_d;
  logic [CNT_W-1:0]   obu_cnt_q, drop_cnt_q;
  logic               err_short_q, err_long_q;
  logic               td_q;
  logic               live_q;
  logic               set_short, set_long;
  logic               hdr_acc, last_beat, fwd;
  logic [REM_W-1:0]   keep_rem;
  logic [BYTES-1:0]   keep;
  route_t             rt;

  assign rt        = route_of(obu_type);
  assign hdr_acc   = obu_valid & obu_ready;
  assign last_beat = (rem_q <= 32'(BYTES));
  assign fwd       = (state_q == ST_FWD);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rem_d     = rem_q;
    obu_ready = 1'b0;
    pl_tready = 1'b0;
    m_tvalid  = '0;
    set_short = 1'b0;
    set_long  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // live_q keeps the header port closed until the first edge after reset.
        obu_ready = live_q;
        if (obu_valid && live_q) begin
          sel_d = rt.sink;
          rem_d = obu_size;
          if (obu_size != '0) state_d = rt.ok ? ST_FWD : ST_DROP;
        end
      end
      ST_FWD, ST_DROP: begin
        if (state_q == ST_FWD) begin
          m_tvalid[sel_q] = pl_tvalid;
          pl_tready       = m_tready[sel_q];
        end else begin
          pl_tready = 1'b1;
        end
        if (pl_tvalid && pl_tready) begin
          rem_d = rem_q - 32'(BYTES);
          if (last_beat) begin
            set_long = ~pl_tlast;
            state_d  = ST_IDLE;
            rem_d    = '0;
          end else if (pl_tlast) begin
            set_short = 1'b1;
            state_d   = ST_IDLE;
            rem_d     = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign keep_rem = last_beat ? rem_q[REM_W-1:0] : REM_W'(BYTES);

  av2_obu_keep_gen #(
    .BYTES(BYTES),
    .REM_W(REM_W)
  ) u_keep (
    .rem_i  (keep_rem),
    .tkeep_o(keep)
  );

  assign m_tdata   = fwd ? pl_tdata : '0;
  assign m_tkeep   = fwd ? keep : '0;
  assign m_tlast   = fwd & (last_beat | pl_tlast);
  assign td_pulse  = td_q;
  assign obu_cnt   = obu_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      rem_q       <= '0;
      obu_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      td_q        <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      live_q  <= 1'b1;
      td_q    <= hdr_acc && (obu_type == OBU_TD);
      if (hdr_acc) obu_cnt_q <= obu_cnt_q + 1'b1;
      if (hdr_acc && !rt.ok && (obu_type != OBU_TD)) drop_cnt_q <= drop_cnt_q + 1'b1;
      // A set event in the same cycle as err_clr wins.
      if (set_short)    err_short_q <= 1'b1;
      else if (err_clr) err_short_q <= 1'b0;
      if (set_long)     err_long_q  <= 1'b1;
      else if (err_clr) err_long_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_av2_obu_dispatch.sv
// Directed bench for av2_obu_dispatch: expected payload beats go into a
// scoreboard queue that a negedge monitor pops on every accepted beat.
module tb_av2_obu_dispatch;

  localparam int DW = 128;
  localparam int BY = DW / 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    obu_type;
  logic [31:0]   obu_size;
  logic          obu_valid;
  logic          obu_ready;
  logic [DW-1:0] pl_tdata;
  logic          pl_tvalid;
  logic          pl_tready;
  logic          pl_tlast;
  logic [DW-1:0] m_tdata;
  logic [BY-1:0] m_tkeep;
  logic          m_tlast;
  logic [2:0]    m_tvalid;
  logic [2:0]    m_tready;
  logic          td_pulse;
  logic [CW-1:0] obu_cnt;
  logic [CW-1:0] drop_cnt;
  logic          err_short;
  logic          err_long;
  logic          err_clr;
  logic          busy;

  av2_obu_dispatch #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .obu_type(obu_type), .obu_size(obu_size), .obu_valid(obu_valid), .obu_ready(obu_ready),
    .pl_tdata(pl_tdata), .pl_tvalid(pl_tvalid), .pl_tready(pl_tready), .pl_tlast(pl_tlast),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .td_pulse(td_pulse), .obu_cnt(obu_cnt), .drop_cnt(drop_cnt),
    .err_short(err_short), .err_long(err_long), .err_clr(err_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  // sink 3 denotes a dropped beat: no m_tvalid, gated data/keep/last.
  typedef struct {
    logic [1:0]    sink;
    logic [DW-1:0] data;
    logic [BY-1:0] keep;
    logic          last;
  } exp_t;

  exp_t expq[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] s, input logic [DW-1:0] d, input logic [BY-1:0] k, input logic l);
    exp_t e;
    e.sink = s; e.data = d; e.keep = k; e.last = l;
    expq.push_back(e);
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (rst_n && pl_tvalid && pl_tready) begin
      logic [2:0] snk;
      exp_t e;
      case (m_tvalid)
        3'b001:  snk = 3'd0;
        3'b010:  snk = 3'd1;
        3'b100:  snk = 3'd2;
        3'b000:  snk = 3'd3;
        default: snk = 3'd7;
      endcase
      if (expq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_beat: got sink %0d with empty scoreboard at %0t", snk, $time);
      end else begin
        e = expq.pop_front();
        chk("beat_sink", DW'(snk), DW'({1'b0, e.sink}));
        chk("beat_data", m_tdata, e.data);
        chk("beat_keep", DW'(m_tkeep), DW'(e.keep));
        chk("beat_last", DW'(m_tlast), DW'(e.last));
      end
    end
  end

  task automatic send_hdr(input logic [3:0] t, input logic [31:0] s);
    int n = 0;
    obu_type = t; obu_size = s; obu_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!obu_ready && n < 50);
    if (!obu_ready) begin
      nvec++; nerr++;
      $display("FAIL hdr_timeout: obu_ready stayed 0, type %0d", t);
    end
    @(posedge clk); #1;
    obu_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic tl);
    int n = 0;
    pl_tdata = d; pl_tlast = tl; pl_tvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!pl_tready && n < 50);
    if (!pl_tready) begin
      nvec++; nerr++;
      $display("FAIL beat_timeout: pl_tready stayed 0");
    end
    @(posedge clk); #1;
    pl_tvalid = 1'b0; pl_tlast = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d0, d1, d2;
    logic [4:0]    pat;
    int            bi;
    rst_n = 1'b0; obu_type = '0; obu_size = '0; obu_valid = 1'b0;
    pl_tdata = '0; pl_tvalid = 1'b0; pl_tlast = 1'b0;
    m_tready = 3'b111; err_clr = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_obu_ready", DW'(obu_ready), '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_m_tvalid", DW'(m_tvalid), '0);
    chk("rst_m_tkeep", DW'(m_tkeep), '0);
    chk("rst_m_tlast", DW'(m_tlast), '0);
    chk("rst_cnts", DW'({obu_cnt, drop_cnt}), '0);
    chk("rst_flags", DW'({err_short, err_long, td_pulse}), '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_obu_ready", DW'(obu_ready), DW'(1));
    chk("idle_pl_tready", DW'(pl_tready), '0);
    @(posedge clk); #1;

    // type 1, 40 bytes: 16 + 16 + 8
    d0 = rnd(); d1 = rnd(); d2 = rnd();
    push(2'd0, d0, 16'hFFFF, 1'b0);
    push(2'd0, d1, 16'hFFFF, 1'b0);
    push(2'd0, d2, 16'h00FF, 1'b1);
    send_hdr(4'd1, 32'd40);
    send_beat(d0, 1'b0);
    send_beat(d1, 1'b0);
    send_beat(d2, 1'b1);
    chk("t1_busy_after", DW'(busy), '0);
    chk("t1_obu_cnt", DW'(obu_cnt), DW'(1));

    // type 4, 32 bytes, tile sink ready pattern 1,0,0,1,1
    d0 = rnd(); d1 = rnd();
    push(2'd2, d0, 16'hFFFF, 1'b0);
    push(2'd2, d1, 16'hFFFF, 1'b1);
    send_hdr(4'd4, 32'd32);
    pat = 5'b11001;
    bi = 0;
    for (int k = 0; k < 5; k++) begin
      m_tready  = {pat[k], 2'b11};
      pl_tvalid = (bi < 2);
      pl_tdata  = (bi == 0) ? d0 : d1;
      pl_tlast  = (bi == 1);
      @(negedge clk);
      if (bi < 2) chk("t2_tready_mirror", DW'(pl_tready), DW'(pat[k]));
      if (pl_tvalid && pl_tready) bi++;
      @(posedge clk); #1;
    end
    pl_tvalid = 1'b0; pl_tlast = 1'b0; m_tready = 3'b111;
    chk("t2_xfers", DW'(bi), DW'(2));
    chk("t2_busy_after", DW'(busy), '0);

    // temporal delimiter with no payload, then a type 6 single beat
    send_hdr(4'd2, 32'd0);
    chk("t3_td_pulse", DW'(td_pulse), DW'(1));
    chk("t3_td_idle", DW'({busy, pl_tready}), '0);
    @(posedge clk); #1;
    chk("t3_td_pulse_end", DW'(td_pulse), '0);
    d0 = rnd();
    push(2'd1, d0, 16'hFFFF, 1'b1);
    send_hdr(4'd6, 32'd16);
    send_beat(d0, 1'b1);
    chk("t3_obu_cnt", DW'(obu_cnt), DW'(4));

    // unsupported type 9, 20 bytes: two dropped beats
    d0 = rnd(); d1 = rnd();
    push(2'd3, '0, '0, 1'b0);
    push(2'd3, '0, '0, 1'b0);
    send_hdr(4'd9, 32'd20);
    chk("t4_drop_cnt", DW'(drop_cnt), DW'(1));
    send_beat(d0, 1'b0);
    send_beat(d1, 1'b1);
    chk("t4_flags", DW'({err_short, err_long, busy}), '0);

    // early tlast on type 3, then clear, then missing tlast
    d0 = rnd(); d1 = rnd(); d2 = rnd();
    push(2'd1, d0, 16'hFFFF, 1'b0);
    push(2'd1, d1, 16'hFFFF, 1'b1);
    send_hdr(4'd3, 32'd48);
    send_beat(d0, 1'b0);
    send_beat(d1, 1'b1);
    chk("t5_err_short", DW'({err_short, err_long, busy}), DW'(3'b100));
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    chk("t5_err_clr", DW'({err_short, err_long}), '0);
    push(2'd1, d2, 16'hFFFF, 1'b1);
    send_hdr(4'd3, 32'd16);
    send_beat(d2, 1'b0);
    chk("t5_err_long", DW'({err_short, err_long, busy}), DW'(3'b010));
    chk("t5_cnts", DW'({obu_cnt, drop_cnt}), DW'({16'd7, 16'd1}));

    // reset mid-OBU after 1 of 4 beats
    d0 = rnd(); d1 = rnd();
    push(2'd0, d0, 16'hFFFF, 1'b0);
    send_hdr(4'd1, 32'd64);
    send_beat(d0, 1'b0);
    m_tready = 3'b000; pl_tdata = d1; pl_tvalid = 1'b1;
    @(negedge clk);
    chk("t6_stalled_valid", DW'({m_tvalid, pl_tready}), DW'(4'b0010));
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_state", DW'({busy, obu_ready, m_tvalid, m_tlast}), '0);
    chk("t6_rst_cnts", DW'({obu_cnt, drop_cnt, err_short, err_long}), '0);
    pl_tvalid = 1'b0; m_tready = 3'b111;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_ready_after", DW'(obu_ready), DW'(1));
    pl_tvalid = 1'b1;
    #1;
    chk("t6_no_sink_activity", DW'({m_tvalid, pl_tready, busy}), '0);
    pl_tvalid = 1'b0;
    @(posedge clk); #1;

    chk("scoreboard_empty", DW'(expq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
